ahb_apb_bridge: RTL
===================

Name: ahb_apb_bridge

Overview:
- AHB-to-APB bridge; sits downstream of the AHB bus fabric as one AHB slave (one bit of the decoder HSEL vector).
- Converts each accepted AHB NONSEQ/SEQ transfer into one APB SETUP+ACCESS transfer to one of NO_OF_APB_SLAVES peripherals.
- Inserts AHB wait states until APB completes and maps PSLVERR to a two-cycle AHB ERROR response.
- APB runs on HCLK; no clock-domain crossing.

Parameters:
- ADDR_WIDTH, 32, AHB and APB address width.
- DATA_WIDTH, 32, AHB and APB data width.
- NO_OF_APB_SLAVES, 4, number of PSEL lines; must be at least 2.
- SLV_ADDR_LSB, 12, lowest HADDR bit of the APB slave index field.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  reset, asynchronous, active-low.
- HSEL  in  1  bridge selected by the AHB decoder.
- HADDR  in  ADDR_WIDTH  AHB address.
- HTRANS  in  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  write=1.
- HSIZE  in  3  accepted; not forwarded.
- HWDATA  in  DATA_WIDTH  AHB write data.
- HREADY  in  1  bus-level HREADY.
- HREADYOUT  out  1  bridge ready.
- HRESP  out  2  OKAY=00, ERROR=01.
- HRDATA  out  DATA_WIDTH  read data.
- PADDR  out  ADDR_WIDTH  APB address.
- PSEL  out  NO_OF_APB_SLAVES  one-hot APB select.
- PENABLE  out  1  APB access phase.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data, muxed externally.
- PREADY  in  1  APB ready, muxed externally.
- PSLVERR  in  1  APB error, muxed externally.

Behaviour:
- Clock and reset: one clock, HCLK; reset HRESETn is asynchronous and active-low.
- Reset values: state=IDLE, HREADYOUT=1, HRESP=00, HRDATA=0, PADDR=0, PSEL=0, PENABLE=0, PWRITE=0, PWDATA=0.
- Accept condition: HSEL & HREADY & HTRANS[1] at a rising edge.
  - On accept, register HADDR to PADDR, HWRITE to PWRITE, and index = HADDR[SLV_ADDR_LSB +: $clog2(NO_OF_APB_SLAVES)].
  - IDLE and BUSY transfers are never accepted; the bridge gives a zero-wait OKAY (HREADYOUT=1, HRESP=00).
- Bad index: if index >= NO_OF_APB_SLAVES, go to ERR1 with no APB activity.
- States:
  - IDLE: HREADYOUT=1. Accepted read -> SETUP. Accepted write -> WDATA. Bad index -> ERR1.
  - WDATA (write data phase): HREADYOUT=0; register HWDATA into PWDATA; -> SETUP.
  - SETUP: PSEL[index]=1, PENABLE=0, HREADYOUT=0; -> ACCESS.
  - ACCESS: PSEL[index]=1, PENABLE=1.
    - PREADY=0: stay in ACCESS, HREADYOUT=0, all APB outputs held stable.
    - PREADY=1 and PSLVERR=0: HREADYOUT=1, HRESP=00, HRDATA=PRDATA combinationally (reads only, 0 for writes).
      - If the accept condition holds in this same cycle, go to SETUP/WDATA/ERR1 for the new transfer; otherwise go to IDLE.
      - PSEL and PENABLE drop in IDLE; on back-to-back the next SETUP drives the new PSEL.
    - PREADY=1 and PSLVERR=1: HREADYOUT=0, HRESP=01; -> ERR2.
  - ERR1: HREADYOUT=0, HRESP=01, PSEL=0; -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=01. If the accept condition holds, take the new transfer; else -> IDLE.
- Latency, AHB data phase in HCLK cycles:
  - Read: 2 + wait cycles (SETUP, ACCESS).
  - Write: 3 + wait cycles (WDATA, SETUP, ACCESS).
  - Bad index: 2 (ERR1, ERR2).
- PADDR, PWRITE and PWDATA change only on accept or in WDATA; they are stable from SETUP through the end of ACCESS.
- HRDATA is 0 whenever not in a completing read ACCESS cycle.
- Reset mid-operation: asynchronous return to reset values at once; PSEL and PENABLE drop in the same cycle.
- HSEL low while busy: ignored; only the accept condition starts transfers.

Test Plan:
- Single read: HADDR=0x0000_1004, HTRANS=NONSEQ, HWRITE=0, PREADY=1, PRDATA=0xDEADBEEF -> PSEL=0010, PADDR=0x1004, SETUP then ACCESS; HRDATA=0xDEADBEEF with HREADYOUT=1 on the 2nd data-phase cycle.
- Single write with 3 APB wait cycles: HADDR=0x0000_3010, HWDATA=0xA5A5_0001 -> PSEL=1000, PWRITE=1, PWDATA=0xA5A50001 stable; HREADYOUT low for 5 cycles, then high with OKAY.
- PSLVERR: read to slave 0 with PREADY=1, PSLVERR=1 -> HRESP=01 for 2 cycles, with HREADYOUT 0 then 1.
- Bad index at NO_OF_APB_SLAVES=3: HADDR=0x0000_3000 -> PSEL stays 000; ERROR response over 2 cycles.
- Back-to-back: NONSEQ read then NONSEQ write presented in the completing cycle -> no IDLE gap; WDATA follows ACCESS immediately.
- Reset: HRESETn low during ACCESS -> PSEL, PENABLE and HREADYOUT return to reset values asynchronously; BUSY and IDLE transfers afterwards -> zero-wait OKAY.

Source files
------------

// File: rtl/ahb_apb_bridge.sv
// ---------------------------------------------------------------------------
// ahb_apb_bridge
//
// Purpose:
//   Single AHB slave that turns each accepted NONSEQ/SEQ transfer into one
//   APB SETUP+ACCESS transfer on one of NO_OF_APB_SLAVES peripherals. The
//   AHB data phase is stretched with wait states until the APB side
//   completes. PSLVERR and out-of-range slave indices become a two-cycle AHB
//   ERROR response. APB runs on HCLK, so there is no clock-domain crossing.
//
// Ports:
//   HCLK, HRESETn         clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS,  AHB address phase from the decoder/master
//   HWRITE, HSIZE
//   HWDATA                AHB write data (data phase)
//   HREADY                bus-level ready (end of previous data phase)
//   HREADYOUT, HRESP,     AHB data-phase response
//   HRDATA
//   PADDR, PSEL, PENABLE, APB master outputs; PSEL is one-hot
//   PWRITE, PWDATA
//   PRDATA, PREADY,       APB responses, muxed externally from the
//   PSLVERR               selected peripheral
// ---------------------------------------------------------------------------
module ahb_apb_bridge #(
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int NO_OF_APB_SLAVES = 4,
    parameter int SLV_ADDR_LSB     = 12
) (
    input  logic                        HCLK,
    input  logic                        HRESETn,

    input  logic                        HSEL,
    input  logic [ADDR_WIDTH-1:0]       HADDR,
    input  logic [1:0]                  HTRANS,
    input  logic                        HWRITE,
    input  logic [2:0]                  HSIZE,
    input  logic [DATA_WIDTH-1:0]       HWDATA,
    input  logic                        HREADY,
    output logic                        HREADYOUT,
    output logic [1:0]                  HRESP,
    output logic [DATA_WIDTH-1:0]       HRDATA,

    output logic [ADDR_WIDTH-1:0]       PADDR,
    output logic [NO_OF_APB_SLAVES-1:0] PSEL,
    output logic                        PENABLE,
    output logic                        PWRITE,
    output logic [DATA_WIDTH-1:0]       PWDATA,
    input  logic [DATA_WIDTH-1:0]       PRDATA,
    input  logic                        PREADY,
    input  logic                        PSLVERR
);

    localparam int IDX_W     = $clog2(NO_OF_APB_SLAVES);
    localparam int IDX_SLOTS = 1 << IDX_W;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WDATA  = 3'd1;
    localparam logic [2:0] ST_SETUP  = 3'd2;
    localparam logic [2:0] ST_ACCESS = 3'd3;
    localparam logic [2:0] ST_ERR1   = 3'd4;
    localparam logic [2:0] ST_ERR2   = 3'd5;

    logic [2:0]            r_state;
    logic [2:0]            w_state_next;
    logic [2:0]            w_start_state;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic                  r_pwrite;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [IDX_W-1:0]      r_idx;

    logic [IDX_W-1:0]      w_haddr_idx;
    logic [IDX_SLOTS-1:0]  w_idx_valid;
    logic                  w_bad_idx;
    logic                  w_accept;
    logic                  w_take;
    logic                  w_apb_active;
    logic                  w_unused;

    // HSIZE is not forwarded and HTRANS[0] does not affect acceptance.
    assign w_unused = ^{HSIZE, HTRANS[0]};

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign w_haddr_idx = HADDR[SLV_ADDR_LSB +: IDX_W];

    // Index field can encode more values than there are slaves when
    // NO_OF_APB_SLAVES is not a power of two; flag those codes.
    always_comb begin
        w_idx_valid = '0;
        for (int i = 0; i < IDX_SLOTS; i++) begin
            w_idx_valid[i] = (i < NO_OF_APB_SLAVES);
        end
    end

    assign w_bad_idx = ~w_idx_valid[w_haddr_idx];
    assign w_accept  = HSEL & HREADY & HTRANS[1];

    // A new transfer is only taken in a cycle where this bridge itself is
    // ending its data phase (HREADYOUT high), which covers IDLE, ERR2 and a
    // successfully completing ACCESS.
    assign w_take = w_accept & HREADYOUT;

    always_comb begin
        if (w_bad_idx) begin
            w_start_state = ST_ERR1;
        end else if (HWRITE) begin
            w_start_state = ST_WDATA;
        end else begin
            w_start_state = ST_SETUP;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_ERR2: begin
                w_state_next = w_take ? w_start_state : ST_IDLE;
            end
            ST_WDATA: begin
                w_state_next = ST_SETUP;
            end
            ST_SETUP: begin
                w_state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    if (PSLVERR) begin
                        w_state_next = ST_ERR2;
                    end else if (w_take) begin
                        w_state_next = w_start_state;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            ST_ERR1: begin
                w_state_next = ST_ERR2;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and APB request registers
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state  <= ST_IDLE;
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
            r_idx    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_take) begin
                r_paddr  <= HADDR;
                r_pwrite <= HWRITE;
                r_idx    <= w_haddr_idx;
            end
            // HWDATA is valid in the cycle after the address phase.
            if (r_state == ST_WDATA) begin
                r_pwdata <= HWDATA;
            end
        end
    end

    // ------------------------------------------------------------------
    // AHB response
    // ------------------------------------------------------------------
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = RESP_OKAY;
        HRDATA    = '0;
        PENABLE   = 1'b0;
        case (r_state)
            ST_WDATA, ST_SETUP: begin
                HREADYOUT = 1'b0;
            end
            ST_ACCESS: begin
                PENABLE = 1'b1;
                if (!PREADY) begin
                    HREADYOUT = 1'b0;
                end else if (PSLVERR) begin
                    // First cycle of the two-cycle ERROR response.
                    HREADYOUT = 1'b0;
                    HRESP     = RESP_ERROR;
                end else if (!r_pwrite) begin
                    HRDATA = PRDATA;
                end
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = RESP_ERROR;
            end
            ST_ERR2: begin
                HRESP = RESP_ERROR;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // APB outputs
    // ------------------------------------------------------------------
    assign w_apb_active = (r_state == ST_SETUP) | (r_state == ST_ACCESS);

    always_comb begin
        PSEL = '0;
        for (int i = 0; i < NO_OF_APB_SLAVES; i++) begin
            PSEL[i] = w_apb_active & (r_idx == IDX_W'(i));
        end
    end

    assign PADDR  = r_paddr;
    assign PWRITE = r_pwrite;
    assign PWDATA = r_pwdata;

endmodule
